// File: rtl/afe_pulser_seq.sv
// Trigger sequencer for the mDOM AFE pulser stage: single shots, counted bursts or
// continuous trains, paced by an internal period or by a synchronised external trigger.
module afe_pulser_seq #(
  parameter int TRIG_HIGH   = 2,
  parameter int SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        stop,
  input  logic        ext_en,
  input  logic        ext_trig,
  input  logic [15:0] n_pulses,
  input  logic [31:0] period,
  input  logic [15:0] width_in,
  output logic        trig,
  output logic [15:0] width,
  output logic        busy,
  output logic        done,
  output logic [15:0] pulse_cnt
);
  // state  | meaning
  // S_IDLE | no run, waiting for start
  // S_FIRE | trig high for TRIG_HIGH cycles
  // S_WAIT | trig low, spacing / holdoff / external edge wait
  // S_DONE | one-cycle done strobe, then idle
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_FIRE = 2'd1, S_WAIT = 2'd2, S_DONE = 2'd3} state_t;

  localparam logic [16:0] HOLD_ADD = 17'(TRIG_HIGH + 3);
  localparam logic [3:0]  HI_LOAD  = 4'(TRIG_HIGH - 1);

  state_t state_q, state_d;
  logic [15:0] n_q, n_d;
  logic [31:0] period_q, period_d;
  logic [15:0] width_q, width_d;
  logic        ext_q, ext_d;
  logic [15:0] cnt_q, cnt_d;
  logic [31:0] spc_q, spc_d;
  logic [16:0] hold_q, hold_d;
  logic [3:0]  hi_q, hi_d;
  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic        prev_q, prev_d, rise_q, rise_d;

  logic [15:0] cfg_width;
  logic [31:0] cfg_period;
  logic [16:0] hold_cyc;
  logic [31:0] eff_period;
  logic        enter_fire, last_pulse;

  // In idle the live inputs are about to be latched, so timing derives from them directly.
  always_comb begin
    cfg_width  = (state_q == S_IDLE) ? width_in : width_q;
    cfg_period = (state_q == S_IDLE) ? period : period_q;
    hold_cyc   = ({1'b0, cfg_width} + 17'd5) / 17'd6 + HOLD_ADD;
    eff_period = (cfg_period > {15'd0, hold_cyc}) ? cfg_period : {15'd0, hold_cyc};
  end

  // Registered edge detect adds the cycle that makes ext latency SYNC_STAGES+2.
  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], ext_trig};
    prev_d = sync_q[SYNC_STAGES-1];
    rise_d = sync_q[SYNC_STAGES-1] & ~prev_q;
  end

  always_comb begin
    state_d    = state_q;
    n_d        = n_q;
    period_d   = period_q;
    width_d    = width_q;
    ext_d      = ext_q;
    cnt_d      = cnt_q;
    spc_d      = (spc_q != 32'd0) ? spc_q - 32'd1 : 32'd0;
    hold_d     = (hold_q != 17'd0) ? hold_q - 17'd1 : 17'd0;
    hi_d       = (hi_q != 4'd0) ? hi_q - 4'd1 : 4'd0;
    enter_fire = 1'b0;
    last_pulse = (n_q != 16'd0) && (cnt_q == n_q);

    case (state_q)
      S_IDLE: begin
        if (start && !stop) begin
          n_d        = n_pulses;
          period_d   = period;
          width_d    = width_in;
          ext_d      = ext_en;
          cnt_d      = 16'd0;
          enter_fire = 1'b1;
        end
      end
      S_FIRE: begin
        if (stop)                state_d = S_DONE;
        else if (hi_q == 4'd0)   state_d = S_WAIT;
      end
      S_WAIT: begin
        if (stop) begin
          state_d = S_DONE;
        end else if (last_pulse) begin
          if (hold_q == 17'd0) state_d = S_DONE;
        end else if (ext_q) begin
          if (hold_q == 17'd0 && rise_q) enter_fire = 1'b1;
        end else if (spc_q == 32'd0) begin
          enter_fire = 1'b1;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    if (enter_fire) begin
      state_d = S_FIRE;
      spc_d   = eff_period - 32'd1;
      hold_d  = hold_cyc - 17'd1;
      hi_d    = HI_LOAD;
      if (cnt_d != 16'hFFFF) cnt_d = cnt_d + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      n_q      <= '0;
      period_q <= '0;
      width_q  <= '0;
      ext_q    <= 1'b0;
      cnt_q    <= '0;
      spc_q    <= '0;
      hold_q   <= '0;
      hi_q     <= '0;
      sync_q   <= '0;
      prev_q   <= 1'b0;
      rise_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      n_q      <= n_d;
      period_q <= period_d;
      width_q  <= width_d;
      ext_q    <= ext_d;
      cnt_q    <= cnt_d;
      spc_q    <= spc_d;
      hold_q   <= hold_d;
      hi_q     <= hi_d;
      sync_q   <= sync_d;
      prev_q   <= prev_d;
      rise_q   <= rise_d;
    end
  end

  assign trig      = (state_q == S_FIRE);
  assign busy      = (state_q != S_IDLE);
  assign done      = (state_q == S_DONE);
  assign width     = width_q;
  assign pulse_cnt = cnt_q;

endmodule
